// File: rtl/uart_byte_rx_if.sv
// Byte-stream link between the UART receiver and the argument loader.
// The receiver side (master) reads the raw line and produces the strobes.
// The peer side (slave) drives the line and consumes the byte stream.
interface uart_byte_rx_if;
    logic       rx;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_frame_err;
    logic       rx_busy;

    modport master (
        input  rx,
        output rx_valid,
        output rx_byte,
        output rx_frame_err,
        output rx_busy
    );

    modport slave (
        output rx,
        input  rx_valid,
        input  rx_byte,
        input  rx_frame_err,
        input  rx_busy
    );
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver with mid-bit sampling.
// Emits a one-cycle rx_valid with rx_byte for each good frame, and a
// one-cycle rx_frame_err (byte discarded) when the stop bit is low.
module uart_byte_rx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int CNT_BITS     = 8
) (
    input logic            clk,
    input logic            rst,
    uart_byte_rx_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        RECOVER
    } state_t;

    // Terminal counts: half a bit for the start check, a full bit afterwards.
    localparam logic [CNT_BITS-1:0] HALF_LAST = CNT_BITS'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_BITS-1:0] BIT_LAST  = CNT_BITS'(CLKS_PER_BIT - 1);
    localparam logic [CNT_BITS-1:0] TIMER_ONE = CNT_BITS'(1);

    logic [1:0]          sync_q;
    logic                rx_s;

    state_t              state_q,   state_d;
    logic [CNT_BITS-1:0] timer_q,   timer_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          shift_q,   shift_d;
    logic [7:0]          byte_q,    byte_d;
    logic                valid_q,   valid_d;
    logic                err_q,     err_d;

    // Two-flop synchronizer for the asynchronous line; resets to idle-high.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], bus.rx};
        end
    end

    assign rx_s = sync_q[1];

    // State, timer, shift register and output strobe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            // NOTE: the shift register is a plain register, not a memory, so
            // it is cleared with everything else to give a known reset state.
            shift_q   <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    // Next-state and datapath updates; strobes default low each cycle.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case
        // leaves one unassigned, which would infer a latch.
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    timer_d = '0;
                end
            end

            START: begin
                if (timer_q == HALF_LAST) begin
                    if (rx_s) begin
                        // Low pulse shorter than half a bit: treat as a glitch.
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        timer_d   = '0;
                        bit_idx_d = '0;
                    end
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end

            DATA: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    // LSB arrives first, so shifting in from the top leaves
                    // bit 0 in shift_q[0] after the eighth sample.
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end

            STOP: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    if (rx_s) begin
                        byte_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RECOVER;
                    end
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end

            RECOVER: begin
                // A held-low line (break) must not decode as 0x00 frames.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.rx_valid     = valid_q;
    assign bus.rx_byte      = byte_q;
    assign bus.rx_frame_err = err_q;
    assign bus.rx_busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx at CLKS_PER_BIT = 8.
// A line driver pushes the expected strobe for each frame into a queue;
// an independent monitor pops and compares whenever the receiver strobes.
`timescale 1ps/1ps
module tb_uart_byte_rx;
    localparam int CPB      = 8;
    localparam int H        = CPB / 2;
    localparam int CLK_PS   = 10000;
    localparam int BIT_PS   = CPB * CLK_PS;
    localparam int SKEW_PS  = 82500;
    localparam int SYNC_LAT = 3;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         cyc;
        bit         chk_time;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    logic [7:0] model_last = 8'h00;

    uart_byte_rx_if bus ();

    uart_byte_rx #(
        .CLKS_PER_BIT(CPB),
        .CNT_BITS    (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #(CLK_PS / 2) clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Return to an idle-high line and realign to 1 ns after a rising edge.
    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(posedge clk);
        #1000;
    endtask

    // Drive one 8N1 frame and record what the receiver must report for it.
    task automatic send_frame(input logic [7:0] data, input bit stop_bit,
                              input int bit_ps, input bit chk_time);
        exp_t e;
        e.is_err   = !stop_bit;
        e.data     = stop_bit ? data : model_last;
        e.cyc      = cyc + SYNC_LAT + H + 9 * CPB;
        e.chk_time = chk_time;
        if (stop_bit) model_last = data;
        sb_q.push_back(e);
        bus.rx = 1'b0;
        #(bit_ps);
        for (int i = 0; i < 8; i++) begin
            bus.rx = data[i];
            #(bit_ps);
        end
        bus.rx = stop_bit;
        #(bit_ps);
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.rx_valid || bus.rx_frame_err) begin
                check("strobe_exclusive", {31'd0, bus.rx_valid & bus.rx_frame_err}, 32'd0);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: valid=%0b err=%0b byte=0x%0h with nothing expected at cycle %0d",
                             bus.rx_valid, bus.rx_frame_err, bus.rx_byte, cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("strobe_kind", {31'd0, bus.rx_frame_err}, {31'd0, e.is_err});
                    check("rx_byte", {24'd0, bus.rx_byte}, {24'd0, e.data});
                    check("busy_at_strobe", {31'd0, bus.rx_busy}, {31'd0, e.is_err});
                    if (e.chk_time) check("strobe_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #(64'd500_000_000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int busy_cnt;
        int n_gap;
        bus.rx = 1'b1;
        rst    = 1'b1;
        repeat (4) @(posedge clk);
        #1000;
        check("reset_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("reset_err",   {31'd0, bus.rx_frame_err}, 32'd0);
        check("reset_busy",  {31'd0, bus.rx_busy}, 32'd0);
        check("reset_byte",  {24'd0, bus.rx_byte}, 32'd0);
        rst = 1'b0;
        idle(4);

        // Single byte, then a back-to-back pair with no idle gap.
        send_frame(8'hA5, 1'b1, BIT_PS, 1'b1);
        idle(5);
        send_frame(8'h00, 1'b1, BIT_PS, 1'b1);
        send_frame(8'hFF, 1'b1, BIT_PS, 1'b1);
        idle(5);

        // Three-clock low glitch: busy for four cycles, no strobe.
        bus.rx = 1'b0;
        repeat (3) @(posedge clk);
        #1000;
        bus.rx = 1'b1;
        busy_cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.rx_busy) busy_cnt++;
        end
        check("glitch_busy_cycles", busy_cnt, 4);
        idle(4);
        send_frame(8'h3C, 1'b1, BIT_PS, 1'b1);
        idle(5);

        // Framing error followed by a held-low line, then a good frame.
        send_frame(8'h5A, 1'b0, BIT_PS, 1'b1);
        repeat (40) @(posedge clk);
        #1000;
        check("recover_busy_while_low", {31'd0, bus.rx_busy}, 32'd1);
        bus.rx = 1'b1;
        repeat (4) @(posedge clk);
        #1000;
        check("recover_busy_after_high", {31'd0, bus.rx_busy}, 32'd0);
        idle(5);
        send_frame(8'h81, 1'b1, BIT_PS, 1'b1);
        idle(5);

        // Reset during data bit 3 of 0xC3; the frame is abandoned and the
        // line released high together with the reset pulse.
        bus.rx = 1'b0;
        #(BIT_PS);
        bus.rx = 1'b1;
        #(BIT_PS);
        bus.rx = 1'b1;
        #(BIT_PS);
        bus.rx = 1'b0;
        #(BIT_PS);
        bus.rx = 1'b0;
        #(BIT_PS / 2);
        rst    = 1'b1;
        bus.rx = 1'b1;
        @(posedge clk);
        #1000;
        rst = 1'b0;
        model_last = 8'h00;
        check("midreset_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("midreset_err",   {31'd0, bus.rx_frame_err}, 32'd0);
        check("midreset_busy",  {31'd0, bus.rx_busy}, 32'd0);
        check("midreset_byte",  {24'd0, bus.rx_byte}, 32'd0);
        idle(10);
        send_frame(8'h42, 1'b1, BIT_PS, 1'b1);
        idle(5);

        // Random bytes at nominal baud with random idle gaps (0 = back-to-back).
        for (int i = 0; i < 20; i++) begin
            send_frame(8'($urandom), 1'b1, BIT_PS, 1'b1);
            n_gap = int'($urandom_range(3, 0));
            if (n_gap != 0) idle(n_gap);
        end
        idle(10);

        // Loader argument stream (6 header bytes plus operand bytes) at +3% bit period.
        for (int i = 0; i < 22; i++) begin
            send_frame(8'($urandom), 1'b1, SKEW_PS, 1'b0);
        end
        idle(20);

        // Drain: every expected strobe must have been seen.
        for (int i = 0; i < 2000 && sb_q.size() != 0; i++) begin
            @(posedge clk);
        end
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

Asynchronous serial receiver that turns the host UART line into a byte stream. It is the stage directly upstream of the argument loader that unpacks the RSA operands (mp_count, e_idx, xbar, mbar, e, n). The receiver oversamples the 8N1 line with a per-bit clock counter and samples each bit at its midpoint. For every good frame it emits a one-cycle `rx_valid` strobe together with `rx_byte`, and the loader consumes that pair directly. Framing errors are flagged and the bad byte is never forwarded.

## Interface
- `CLKS_PER_BIT`, default 104: system clocks per bit period (12 MHz / 115200). Must be ≥ 4.
- `CNT_BITS`, default 8: bit-timer width. Must satisfy `2^CNT_BITS > CLKS_PER_BIT`.
- `clk`  in  1: single system clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `rx`  in  1: raw asynchronous UART line. Idle is high.
- `rx_valid`  out  1: one-cycle strobe; `rx_byte` is valid while it is high.
- `rx_byte`  out  8: last correctly framed byte. Holds its value between strobes.
- `rx_frame_err`  out  1: one-cycle strobe when the stop bit is sampled low.
- `rx_busy`  out  1: high in every state except IDLE.

## Operation
- **Input synchronizer.** `rx` passes through a 2-FF synchronizer. Both FFs reset to 1. All decisions below use the synchronized signal `rx_s`.
- **Frame format.** 8N1, data LSB first. H below means `CLKS_PER_BIT/2`, truncated.
- **States:** IDLE, START, DATA, STOP, RECOVER.
- **IDLE**
  - `rx_s == 0`: go to START and clear the timer.
- **START**
  - The timer counts to H−1.
  - At that point, if `rx_s == 1` the low pulse was a glitch: return to IDLE with no output.
  - Otherwise clear the timer and the bit index, then go to DATA.
- **DATA**
  - The timer counts to `CLKS_PER_BIT−1`, then `rx_s` is shifted into the shift register from the MSB end (LSB first on the wire).
  - After bit index 7 is sampled, go to STOP.
- **STOP**
  - The timer counts to `CLKS_PER_BIT−1`, then `rx_s` is sampled.
  - `rx_s == 1`: load `rx_byte` from the shift register, pulse `rx_valid`, go to IDLE.
  - `rx_s == 0`: pulse `rx_frame_err`, leave `rx_byte` unchanged, go to RECOVER.
- **RECOVER**
  - Wait for `rx_s == 1`, then go to IDLE.
  - This keeps a break condition (line held low) from being decoded as 0x00 frames.
- **Exclusivity.** `rx_valid` and `rx_frame_err` are never high in the same cycle.
- **No backpressure.** The consumer must accept every strobe. The minimum spacing between strobes is 10·`CLKS_PER_BIT` − H cycles.
- **Reset** (any cycle, including mid-frame):
  - state becomes IDLE, timer and bit index become 0;
  - `rx_valid`, `rx_frame_err` and `rx_busy` are 0, `rx_byte` is 0x00, shift register is 0;
  - synchronizer FFs are 1.
  - A partially received frame is discarded silently. Reception restarts at the next falling edge seen after reset.

## Timing
- **Reference edge.** Let E be the edge at which IDLE registers `rx_s == 0`. E is 2–3 clocks after the pin's falling edge, because of the synchronizer.
- **Sample edges:**
  - start check at E + H;
  - data bit k (k = 0..7) at E + H + (k+1)·`CLKS_PER_BIT`;
  - stop bit at E + H + 9·`CLKS_PER_BIT`.
- **Strobes.** `rx_valid` or `rx_frame_err` is registered at the stop-sample edge and is high for exactly that one cycle. `rx_byte` updates on the same edge.
- **Back-to-back frames.** IDLE is re-entered at the midpoint of the stop bit, so a start bit immediately following the stop bit is captured.
- **Busy.** `rx_busy` rises on edge E and falls on the edge that enters IDLE.
- **Timing tolerance.** Mid-bit sampling tolerates ±4% total baud mismatch at `CLKS_PER_BIT` ≥ 16.
- **Timer rules.** The timer wraps only by explicit clear. It never rolls over at the `CNT_BITS` limit, because the parameter constraint prevents it.

## Test plan
All scenarios use `CLKS_PER_BIT = 8`, so H = 4.
- **Single byte.** Drive frame 0xA5 → exactly one `rx_valid` pulse at E+76, `rx_byte` = 0xA5, `rx_frame_err` stays 0, `rx_busy` falls at E+76.
- **Back-to-back bytes.** Drive 0x00 then 0xFF with no idle gap → two `rx_valid` pulses 80 clocks apart, bytes 0x00 then 0xFF.
- **Glitch.** Hold `rx` low for 3 clocks, then high → no strobe; `rx_busy` pulses high for 4 cycles; the next proper frame 0x3C is received correctly.
- **Framing error.**
  - Drive 0x5A with stop bit = 0, then hold the line low for 40 more clocks → one `rx_frame_err` pulse, no `rx_valid`, `rx_byte` keeps its previous value, `rx_busy` stays high until the line returns high.
  - A following frame 0x81 is then received correctly.
- **Reset mid-frame.** Assert `rst` for 1 clock during data bit 3 of 0xC3 → all outputs 0 on the next cycle, no strobe for the aborted frame; the following frame 0x42 yields `rx_byte` = 0x42.
- **Loader stream with baud skew.** Send the 6-byte-plus-operand argument stream with the bit period stretched to 8.25 clocks (+3%) → all bytes delivered in order, no frame errors.
